// File: rtl/mac_head_tx_gen.sv
// Ethernet MAC header generator: latches dst/src/EtherType on a start pulse and
// serialises the header as DW-bit words; 802.1Q tagging is built only when MAC_HEAD_TX_VLAN_EN is defined.
module mac_head_tx_gen #(
  parameter int DW  = 32,
  parameter int BEW = $clog2(DW/8)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           mac_start,
  output logic           mac_start_rdy,
  input  logic [47:0]    mac_dst_addr,
  input  logic [47:0]    mac_src_addr,
  input  logic [15:0]    mac_type,
  input  logic           mac_vlan_en,
  input  logic [15:0]    mac_vlan_tci,
  input  logic           mac_abort,
  output logic           mac_busy,
  output logic [DW-1:0]  mac_data_out,
  output logic [BEW-1:0] mac_be_out,
  output logic           mac_last_out,
  output logic           mac_data_out_rdy,
  input  logic           mac_data_out_sel,
  input  logic           mac_data_out_rd
);

  localparam int BPW      = DW / 8;
  localparam int MAXW     = 192 / DW;
  localparam int N_UNTAG  = (14 + BPW - 1) / BPW;
  localparam int N_TAG    = (18 + BPW - 1) / BPW;
  localparam int BE_UNTAG = N_UNTAG * BPW - 14;
  localparam int BE_TAG   = N_TAG * BPW - 18;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SEND = 1'b1;

  logic [0:0]  r_state;
  logic [3:0]  r_ptr;
  logic [47:0] r_act_dst;
  logic [47:0] r_act_src;
  logic [15:0] r_act_type;
  logic        r_pend_valid;
  logic [47:0] r_pend_dst;
  logic [47:0] r_pend_src;
  logic [15:0] r_pend_type;

  logic        w_act_tag;
  logic [15:0] w_act_tci;
  logic        w_send;
  logic        w_rd_ev;
  logic [3:0]  w_last_idx;
  logic        w_at_last;
  logic        w_end;
  logic        w_start_acc;
  logic        w_load_act_in;
  logic        w_load_act_pend;
  logic        w_load_pend;

  assign w_send      = (r_state == S_SEND);
  assign w_rd_ev     = w_send & mac_data_out_sel & mac_data_out_rd;
  assign w_last_idx  = w_act_tag ? 4'(N_TAG - 1) : 4'(N_UNTAG - 1);
  assign w_at_last   = (r_ptr == w_last_idx);
  assign w_end       = w_rd_ev & w_at_last;
  assign w_start_acc = mac_start & ~r_pend_valid & ~mac_abort;

  // A start arriving with the final read goes straight to the active set when no header is pending.
  assign w_load_act_in   = w_start_acc & (~w_send | w_end);
  assign w_load_act_pend = ~mac_abort & w_end & r_pend_valid;
  assign w_load_pend     = w_start_acc & w_send & ~w_end;

  // NOTE: sequential state uses <= so every register updates from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_ptr        <= '0;
      r_act_dst    <= '0;
      r_act_src    <= '0;
      r_act_type   <= '0;
      r_pend_valid <= 1'b0;
      r_pend_dst   <= '0;
      r_pend_src   <= '0;
      r_pend_type  <= '0;
    end else if (mac_abort) begin
      r_state      <= S_IDLE;
      r_ptr        <= '0;
      r_pend_valid <= 1'b0;
    end else begin
      if (w_load_act_in) begin
        r_act_dst  <= mac_dst_addr;
        r_act_src  <= mac_src_addr;
        r_act_type <= mac_type;
      end else if (w_load_act_pend) begin
        r_act_dst  <= r_pend_dst;
        r_act_src  <= r_pend_src;
        r_act_type <= r_pend_type;
      end

      if (w_load_pend) begin
        r_pend_valid <= 1'b1;
        r_pend_dst   <= mac_dst_addr;
        r_pend_src   <= mac_src_addr;
        r_pend_type  <= mac_type;
      end else if (w_load_act_pend) begin
        r_pend_valid <= 1'b0;
      end

      if (w_load_act_in | w_load_act_pend) begin
        r_state <= S_SEND;
        r_ptr   <= '0;
      end else if (w_end) begin
        r_state <= S_IDLE;
        r_ptr   <= '0;
      end else if (w_rd_ev) begin
        r_ptr <= r_ptr + 4'd1;
      end
    end
  end

`ifdef MAC_HEAD_TX_VLAN_EN
  logic        r_act_tag;
  logic [15:0] r_act_tci;
  logic        r_pend_tag;
  logic [15:0] r_pend_tci;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_act_tag  <= 1'b0;
      r_act_tci  <= '0;
      r_pend_tag <= 1'b0;
      r_pend_tci <= '0;
    end else begin
      if (w_load_act_in) begin
        r_act_tag <= mac_vlan_en;
        r_act_tci <= mac_vlan_tci;
      end else if (w_load_act_pend) begin
        r_act_tag <= r_pend_tag;
        r_act_tci <= r_pend_tci;
      end
      if (w_load_pend) begin
        r_pend_tag <= mac_vlan_en;
        r_pend_tci <= mac_vlan_tci;
      end
    end
  end

  assign w_act_tag = r_act_tag;
  assign w_act_tci = r_act_tci;
`else
  logic w_unused_vlan;

  assign w_unused_vlan = ^{mac_vlan_en, mac_vlan_tci};
  assign w_act_tag     = 1'b0;
  assign w_act_tci     = 16'h0000;
`endif

  logic [143:0]  w_hdr;
  logic [191:0]  w_pad;
  logic [DW-1:0] w_words [16];

  assign w_hdr = w_act_tag ? {r_act_dst, r_act_src, 16'h8100, w_act_tci, r_act_type}
                           : {r_act_dst, r_act_src, r_act_type, 32'h0000_0000};
  assign w_pad = {w_hdr, 48'h0};

  // Word table is padded to 16 entries so the 4-bit pointer indexes it without truncation.
  for (genvar gi = 0; gi < 16; gi++) begin : g_word
    if (gi < MAXW) begin : g_live
      assign w_words[gi] = w_pad[191 - gi*DW -: DW];
    end else begin : g_zero
      assign w_words[gi] = '0;
    end
  end

  assign mac_start_rdy    = ~r_pend_valid;
  assign mac_busy         = w_send;
  assign mac_data_out_rdy = w_send;
  assign mac_data_out     = w_send ? w_words[r_ptr] : '0;
  assign mac_last_out     = w_send & w_at_last;
  assign mac_be_out       = (w_send & w_at_last) ? (w_act_tag ? BEW'(BE_TAG) : BEW'(BE_UNTAG)) : '0;

endmodule

// File: tb/tb_mac_head_tx_gen.sv
// Directed bench for mac_head_tx_gen: DW=32 vector table plus hand sequences, and a DW=16/64 sweep.
module tb_mac_head_tx_gen;

`ifdef MAC_HEAD_TX_VLAN_EN
  localparam bit TAG_ON = 1'b1;
`else
  localparam bit TAG_ON = 1'b0;
`endif

  localparam logic [31:0] W0 = 32'h0011_2233;
  localparam logic [31:0] W1 = 32'h4455_6677;
  localparam logic [31:0] W2 = 32'h8899_AABB;
  localparam logic [31:0] W3 = 32'h0800_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        mac_start = 1'b0;
  logic        mac_abort = 1'b0;
  logic        vlan_en = 1'b0;
  logic [47:0] dst = 48'h0011_2233_4455;
  logic [47:0] src = 48'h6677_8899_AABB;
  logic [15:0] typ = 16'h0800;
  logic [15:0] tci = 16'h0064;
  logic sel32 = 1'b0, rd32 = 1'b0, sel64 = 1'b0, rd64 = 1'b0, sel16 = 1'b0, rd16 = 1'b0;

  logic        srdy32, busy32, rdy32, last32;
  logic [31:0] data32;
  logic [1:0]  be32;
  logic        srdy64, busy64, rdy64, last64;
  logic [63:0] data64;
  logic [2:0]  be64;
  logic        srdy16, busy16, rdy16, last16;
  logic [15:0] data16;
  logic [0:0]  be16;

  mac_head_tx_gen #(.DW(32)) u_dut32 (
    .clk(clk), .rst(rst), .mac_start(mac_start), .mac_start_rdy(srdy32),
    .mac_dst_addr(dst), .mac_src_addr(src), .mac_type(typ),
    .mac_vlan_en(vlan_en), .mac_vlan_tci(tci), .mac_abort(mac_abort),
    .mac_busy(busy32), .mac_data_out(data32), .mac_be_out(be32), .mac_last_out(last32),
    .mac_data_out_rdy(rdy32), .mac_data_out_sel(sel32), .mac_data_out_rd(rd32)
  );

  mac_head_tx_gen #(.DW(64)) u_dut64 (
    .clk(clk), .rst(rst), .mac_start(mac_start), .mac_start_rdy(srdy64),
    .mac_dst_addr(dst), .mac_src_addr(src), .mac_type(typ),
    .mac_vlan_en(vlan_en), .mac_vlan_tci(tci), .mac_abort(mac_abort),
    .mac_busy(busy64), .mac_data_out(data64), .mac_be_out(be64), .mac_last_out(last64),
    .mac_data_out_rdy(rdy64), .mac_data_out_sel(sel64), .mac_data_out_rd(rd64)
  );

  mac_head_tx_gen #(.DW(16)) u_dut16 (
    .clk(clk), .rst(rst), .mac_start(mac_start), .mac_start_rdy(srdy16),
    .mac_dst_addr(dst), .mac_src_addr(src), .mac_type(typ),
    .mac_vlan_en(vlan_en), .mac_vlan_tci(tci), .mac_abort(mac_abort),
    .mac_busy(busy16), .mac_data_out(data16), .mac_be_out(be16), .mac_last_out(last16),
    .mac_data_out_rdy(rdy16), .mac_data_out_sel(sel16), .mac_data_out_rd(rd16)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk32(input string name, input logic rdy, input logic [31:0] data,
                       input logic [1:0] be, input logic last, input logic srdy);
    check({name, "_rdy"},  {63'd0, rdy32},  {63'd0, rdy});
    check({name, "_busy"}, {63'd0, busy32}, {63'd0, rdy});
    check({name, "_data"}, {32'd0, data32}, {32'd0, data});
    check({name, "_be"},   {62'd0, be32},   {62'd0, be});
    check({name, "_last"}, {63'd0, last32}, {63'd0, last});
    check({name, "_srdy"}, {63'd0, srdy32}, {63'd0, srdy});
  endtask

  typedef struct {
    logic        start;
    logic        sel;
    logic        rd;
    logic        rdy;
    logic [31:0] data;
    logic [1:0]  be;
    logic        last;
  } vec_t;

  vec_t vecs[$];

  logic [31:0] e32 [5];
  logic [63:0] e64 [3];
  logic [15:0] e16 [9];

  initial begin
    // basic: continuous read
    vecs.push_back(vec_t'{1'b1, 1'b1, 1'b1, 1'b1, W0, 2'd0, 1'b0});
    vecs.push_back(vec_t'{1'b0, 1'b1, 1'b1, 1'b1, W1, 2'd0, 1'b0});
    vecs.push_back(vec_t'{1'b0, 1'b1, 1'b1, 1'b1, W2, 2'd0, 1'b0});
    vecs.push_back(vec_t'{1'b0, 1'b1, 1'b1, 1'b1, W3, 2'd2, 1'b1});
    vecs.push_back(vec_t'{1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 2'd0, 1'b0});
    // stall: rd toggling
    vecs.push_back(vec_t'{1'b1, 1'b1, 1'b0, 1'b1, W0, 2'd0, 1'b0});
    vecs.push_back(vec_t'{1'b0, 1'b1, 1'b1, 1'b1, W1, 2'd0, 1'b0});
    vecs.push_back(vec_t'{1'b0, 1'b1, 1'b0, 1'b1, W1, 2'd0, 1'b0});
    vecs.push_back(vec_t'{1'b0, 1'b1, 1'b1, 1'b1, W2, 2'd0, 1'b0});
    vecs.push_back(vec_t'{1'b0, 1'b1, 1'b0, 1'b1, W2, 2'd0, 1'b0});
    vecs.push_back(vec_t'{1'b0, 1'b1, 1'b1, 1'b1, W3, 2'd2, 1'b1});
    vecs.push_back(vec_t'{1'b0, 1'b1, 1'b0, 1'b1, W3, 2'd2, 1'b1});
    vecs.push_back(vec_t'{1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 2'd0, 1'b0});
    // sel=0 with rd=1 must not advance
    vecs.push_back(vec_t'{1'b1, 1'b0, 1'b1, 1'b1, W0, 2'd0, 1'b0});
    vecs.push_back(vec_t'{1'b0, 1'b0, 1'b1, 1'b1, W0, 2'd0, 1'b0});
    vecs.push_back(vec_t'{1'b0, 1'b0, 1'b1, 1'b1, W0, 2'd0, 1'b0});
    vecs.push_back(vec_t'{1'b0, 1'b1, 1'b1, 1'b1, W1, 2'd0, 1'b0});
    vecs.push_back(vec_t'{1'b0, 1'b1, 1'b1, 1'b1, W2, 2'd0, 1'b0});
    vecs.push_back(vec_t'{1'b0, 1'b1, 1'b1, 1'b1, W3, 2'd2, 1'b1});
    vecs.push_back(vec_t'{1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 2'd0, 1'b0});

    @(negedge clk);
    step();
    step();
    chk32("reset", 1'b0, 32'd0, 2'd0, 1'b0, 1'b1);
    rst = 1'b0;
    step();
    chk32("post_reset", 1'b0, 32'd0, 2'd0, 1'b0, 1'b1);

    for (int i = 0; i < vecs.size(); i++) begin
      mac_start = vecs[i].start;
      sel32     = vecs[i].sel;
      rd32      = vecs[i].rd;
      step();
      chk32($sformatf("vec%0d", i), vecs[i].rdy, vecs[i].data, vecs[i].be, vecs[i].last, 1'b1);
    end

    // back-to-back with pending buffer; third start dropped
    sel32 = 1'b1; rd32 = 1'b1;
    mac_start = 1'b1; typ = 16'h0800;
    step(); chk32("b2b_a0", 1'b1, W0, 2'd0, 1'b0, 1'b1);
    mac_start = 1'b0;
    step(); chk32("b2b_a1", 1'b1, W1, 2'd0, 1'b0, 1'b1);
    mac_start = 1'b1; typ = 16'h86DD;
    step(); chk32("b2b_a2", 1'b1, W2, 2'd0, 1'b0, 1'b0);
    typ = 16'hAAAA;
    step(); chk32("b2b_a3", 1'b1, W3, 2'd2, 1'b1, 1'b0);
    mac_start = 1'b0;
    step(); chk32("b2b_b0", 1'b1, W0, 2'd0, 1'b0, 1'b1);
    step(); chk32("b2b_b1", 1'b1, W1, 2'd0, 1'b0, 1'b1);
    step(); chk32("b2b_b2", 1'b1, W2, 2'd0, 1'b0, 1'b1);
    step(); chk32("b2b_b3", 1'b1, 32'h86DD_0000, 2'd2, 1'b1, 1'b1);
    step(); chk32("b2b_end", 1'b0, 32'd0, 2'd0, 1'b0, 1'b1);

    // start coincident with last read, pending empty
    mac_start = 1'b1; typ = 16'h0800;
    step(); chk32("coin_a0", 1'b1, W0, 2'd0, 1'b0, 1'b1);
    mac_start = 1'b0;
    step(); step();
    step(); chk32("coin_a3", 1'b1, W3, 2'd2, 1'b1, 1'b1);
    mac_start = 1'b1; typ = 16'h1234;
    step(); chk32("coin_b0", 1'b1, W0, 2'd0, 1'b0, 1'b1);
    mac_start = 1'b0;
    step(); step();
    step(); chk32("coin_b3", 1'b1, 32'h1234_0000, 2'd2, 1'b1, 1'b1);
    step(); chk32("coin_end", 1'b0, 32'd0, 2'd0, 1'b0, 1'b1);

    // abort at word 2 with pending full; coincident start ignored
    mac_start = 1'b1; typ = 16'h0800;
    step(); chk32("abt_w0", 1'b1, W0, 2'd0, 1'b0, 1'b1);
    typ = 16'h86DD;
    step(); chk32("abt_w1", 1'b1, W1, 2'd0, 1'b0, 1'b0);
    mac_start = 1'b0;
    step(); chk32("abt_w2", 1'b1, W2, 2'd0, 1'b0, 1'b0);
    mac_abort = 1'b1; mac_start = 1'b1; typ = 16'hBEEF;
    step(); chk32("abt_now", 1'b0, 32'd0, 2'd0, 1'b0, 1'b1);
    mac_abort = 1'b0; mac_start = 1'b0;
    step(); chk32("abt_idle", 1'b0, 32'd0, 2'd0, 1'b0, 1'b1);
    mac_start = 1'b1; typ = 16'h0800;
    step(); chk32("abt_new0", 1'b1, W0, 2'd0, 1'b0, 1'b1);
    mac_start = 1'b0;
    step(); step();
    step(); chk32("abt_new3", 1'b1, W3, 2'd2, 1'b1, 1'b1);
    step(); chk32("abt_end", 1'b0, 32'd0, 2'd0, 1'b0, 1'b1);

    // tagged request at DW=32 (untagged output when tagging is not built)
    if (TAG_ON) e32 = '{W0, W1, W2, 32'h8100_0064, W3};
    else        e32 = '{W0, W1, W2, W3, 32'd0};
    vlan_en = 1'b1; mac_start = 1'b1;
    for (int i = 0; i < (TAG_ON ? 5 : 4); i++) begin
      step();
      mac_start = 1'b0;
      chk32($sformatf("tag32_w%0d", i), 1'b1, e32[i],
            (i == (TAG_ON ? 4 : 3)) ? 2'd2 : 2'd0, i == (TAG_ON ? 4 : 3), 1'b1);
    end
    step(); chk32("tag32_end", 1'b0, 32'd0, 2'd0, 1'b0, 1'b1);
    vlan_en = 1'b0;

    // width sweep from a clean reset
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("sweep_rst_busy64", {63'd0, busy64}, 64'd0);
    check("sweep_rst_busy16", {63'd0, busy16}, 64'd0);
    check("sweep_rst_srdy64", {63'd0, srdy64}, 64'd1);
    check("sweep_rst_srdy16", {63'd0, srdy16}, 64'd1);
    sel64 = 1'b1; rd64 = 1'b1; sel16 = 1'b1; rd16 = 1'b1;
    for (int t = 0; t < 2; t++) begin
      automatic bit eff = (t == 1) && TAG_ON;
      automatic int n64 = eff ? 3 : 2;
      automatic int n16 = eff ? 9 : 7;
      if (eff) begin
        e64 = '{64'h0011_2233_4455_6677, 64'h8899_AABB_8100_0064, 64'h0800_0000_0000_0000};
        e16 = '{16'h0011, 16'h2233, 16'h4455, 16'h6677, 16'h8899, 16'hAABB,
                16'h8100, 16'h0064, 16'h0800};
      end else begin
        e64 = '{64'h0011_2233_4455_6677, 64'h8899_AABB_0800_0000, 64'd0};
        e16 = '{16'h0011, 16'h2233, 16'h4455, 16'h6677, 16'h8899, 16'hAABB,
                16'h0800, 16'h0000, 16'h0000};
      end
      vlan_en = (t == 1); mac_start = 1'b1;
      for (int i = 0; i <= n16; i++) begin
        step();
        mac_start = 1'b0;
        if (i < n16) begin
          check($sformatf("sw%0d_d16_w%0d", t, i), {48'd0, data16}, {48'd0, e16[i]});
          check($sformatf("sw%0d_l16_w%0d", t, i), {63'd0, last16}, {63'd0, i == n16 - 1});
          check($sformatf("sw%0d_be16_w%0d", t, i), {63'd0, be16}, 64'd0);
        end else begin
          check($sformatf("sw%0d_busy16_end", t), {63'd0, busy16}, 64'd0);
        end
        if (i < n64) begin
          check($sformatf("sw%0d_d64_w%0d", t, i), data64, e64[i]);
          check($sformatf("sw%0d_l64_w%0d", t, i), {63'd0, last64}, {63'd0, i == n64 - 1});
          check($sformatf("sw%0d_be64_w%0d", t, i), {61'd0, be64},
                (i == n64 - 1) ? (eff ? 64'd6 : 64'd2) : 64'd0);
        end else if (i == n64) begin
          check($sformatf("sw%0d_busy64_end", t), {63'd0, busy64}, 64'd0);
        end
      end
    end
    vlan_en = 1'b0;

    // synchronous reset mid-SEND with pending full
    mac_start = 1'b1;
    step();
    step();
    check("mid_srdy32_pend", {63'd0, srdy32}, 64'd0);
    check("mid_d16_w1", {48'd0, data16}, 64'h2233);
    mac_start = 1'b0; rst = 1'b1;
    step();
    chk32("mid_rst32", 1'b0, 32'd0, 2'd0, 1'b0, 1'b1);
    check("mid_rst_busy64", {63'd0, busy64}, 64'd0);
    check("mid_rst_rdy64",  {63'd0, rdy64},  64'd0);
    check("mid_rst_d64",    data64,          64'd0);
    check("mid_rst_srdy64", {63'd0, srdy64}, 64'd1);
    check("mid_rst_busy16", {63'd0, busy16}, 64'd0);
    check("mid_rst_rdy16",  {63'd0, rdy16},  64'd0);
    check("mid_rst_d16",    {48'd0, data16}, 64'd0);
    check("mid_rst_last16", {63'd0, last16}, 64'd0);
    check("mid_rst_srdy16", {63'd0, srdy16}, 64'd1);
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
